// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and widths for the memory-side bus responder.
package mem_bus_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int WAIT_CNT_W = 4;
endpackage

// File: rtl/mem_bus_sram.sv
// mem_bus_sram: single-port synchronous RAM with one-cycle registered read.
module mem_bus_sram
    import mem_bus_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: accepts one read/write at a time, waits WAIT_STATES cycles,
// accesses local RAM and returns data/status over a valid-ready response.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);
    state_t                state, state_nx;
    logic [WAIT_CNT_W-1:0] cnt, cnt_nx;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata, ram_q;
    logic                  write, err, rd_ok, in_range, accept, access;

    assign req_ready  = state == IDLE;
    assign busy       = !req_ready;
    assign resp_valid = state == RESP;
    assign accept     = req_valid && req_ready;
    assign access     = state == ACCESS;
    assign in_range   = addr[ADDR_W-1:DEPTH_LOG2] == '0;
    assign resp_err   = resp_valid && err;
    // RAM output only changes on a read launch, so it stays stable through RESP
    assign resp_rdata = (resp_valid && rd_ok) ? ram_q : '0;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (accept) begin
                state_nx = (WAIT_STATES == 0) ? ACCESS : WAIT;
                cnt_nx   = WAIT_CNT_W'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
            end
            WAIT: begin
                state_nx = (cnt == '0) ? ACCESS : WAIT;
                cnt_nx   = (cnt == '0) ? cnt : cnt - 1'b1;
            end
            ACCESS: state_nx = RESP;
            RESP: state_nx = resp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            err   <= 1'b0;
            rd_ok <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (access) begin
                err   <= !in_range;
                rd_ok <= in_range && !write;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr  <= req_addr;
            write <= req_write;
            wdata <= req_wdata;
        end
    end

    mem_bus_sram #(.DEPTH_LOG2(DEPTH_LOG2)) u_sram (
        .clk  (clk),
        .we   (access && write && in_range),
        .re   (access && !write && in_range),
        .addr (addr[DEPTH_LOG2-1:0]),
        .wdata(wdata),
        .rdata(ram_q)
    );
endmodule
